// File: rtl/int_div_seq_if.sv
// Handshake bundle for int_div_seq: operand channel (in_*) and result
// channel (out_*). Both channels use the same valid/ready rule: a beat
// transfers on a rising clk edge where valid and ready are both high (the
// divider also needs en=1); a producer holds valid and its payload steady
// until that edge.
// Optional feature macro: INT_DIV_SIGNED_EN adds the is_signed operand flag.
interface int_div_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
`ifdef INT_DIV_SIGNED_EN
    logic                  is_signed;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  div_by_zero;

`ifdef INT_DIV_SIGNED_EN
    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/int_div_seq.sv
// Sequential restoring divider: one quotient bit per enabled cycle,
// IDLE -> CALC -> DONE -> IDLE, one division in flight. en=0 freezes all
// state. Quotient and remainder live in the shift registers themselves, so
// they are held stable for the whole DONE state.
// Optional feature macro: INT_DIV_SIGNED_EN (is_signed operand flag plus a
// FIX state that restores the result signs after the magnitude division).
module int_div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    int_div_seq_if.slave     bus,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
`ifdef INT_DIV_SIGNED_EN
        FIX  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] dvsr_q;
    logic                  out_valid_q;
    logic                  dbz_q;

    logic                  accept;
    logic [DATA_WIDTH:0]   rem_wide;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

`ifdef INT_DIV_SIGNED_EN
    logic sgn_q;
    logic neg_quo_q;
    logic neg_rem_q;
    logic a_neg;
    logic b_neg;

    // Signed operands enter CALC as magnitudes; the signs are kept for FIX.
    assign a_neg = bus.is_signed & bus.dividend[DATA_WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[DATA_WIDTH-1];
    assign op_a  = a_neg ? -bus.dividend : bus.dividend;
    assign op_b  = b_neg ? -bus.divisor  : bus.divisor;
`else
    assign op_a  = bus.dividend;
    assign op_b  = bus.divisor;
`endif

    assign accept   = en & bus.in_valid & (state == IDLE);
    // Shifted partial remainder with the next dividend bit, one bit wider so
    // the trial subtraction's borrow lands in the MSB.
    assign rem_wide = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial    = rem_wide - {1'b0, dvsr_q};

    assign bus.in_ready    = en & (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state;

    // Control FSM and iteration datapath; everything advances only when en=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef INT_DIV_SIGNED_EN
            sgn_q       <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= '0;
                        if (bus.divisor == '0) begin
                            // Zero divisor short-circuits straight to the result.
                            quo_q       <= '1;
                            rem_q       <= bus.dividend;
                            dvsr_q      <= '0;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
`ifdef INT_DIV_SIGNED_EN
                            sgn_q       <= 1'b0;
`endif
                        end else begin
                            quo_q  <= op_a;
                            rem_q  <= '0;
                            dvsr_q <= op_b;
                            dbz_q  <= 1'b0;
                            state  <= CALC;
`ifdef INT_DIV_SIGNED_EN
                            sgn_q     <= bus.is_signed;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
`endif
                        end
                    end
                end
                CALC: begin
                    if (!trial[DATA_WIDTH]) begin
                        rem_q <= trial[DATA_WIDTH-1:0];
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_wide[DATA_WIDTH-1:0];
                        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
`ifdef INT_DIV_SIGNED_EN
                        if (sgn_q) begin
                            state <= FIX;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
`else
                        state       <= DONE;
                        out_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef INT_DIV_SIGNED_EN
                FIX: begin
                    // Most-negative / -1 wraps back to most-negative here.
                    if (neg_quo_q) quo_q <= -quo_q;
                    if (neg_rem_q) rem_q <= -rem_q;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_div_seq.sv
// Bench for int_div_seq: directed scenarios plus a random sweep. Expected
// {div_by_zero, quotient, remainder} tuples are queued at accept time and
// popped when the result handshake is presented.
module tb_int_div_seq;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] dbg_state;

    int_div_seq_if #(.DATA_WIDTH(W)) bus ();

    int_div_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    logic [2*W:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference result {dbz, q, r}, built from the language's own operators.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (sgn) begin
            if (a == most_neg && b == '1) return {1'b0, most_neg, {W{1'b0}}};
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, q, r};
    endfunction

    task automatic drive_idle;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
`ifdef INT_DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
    endtask

    // One complete division: accept, wait (optionally with an en=0 window),
    // hold the result under back-pressure, then complete the output handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input int hold, input int off_at, input int off_len,
                          input string name);
        logic [2*W:0] exp;
        logic [2*W:0] got;
        logic [2*W:0] first;
        int lat, guard, busy_bad, unstable, exp_lat;

        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
        else pass_cnt++;

        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef INT_DIV_SIGNED_EN
        bus.is_signed = sgn;
`endif
        exp_q.push_back(model(a, b, sgn));
        if (b == '0) exp_lat = 1;
        else if (sgn) exp_lat = W + 2 + off_len;
        else exp_lat = W + 1 + off_len;

        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) busy_bad++;
            en = !(lat >= off_at && lat < off_at + off_len);
            @(posedge clk); @(negedge clk);
            lat++;
        end
        en = 1'b1;

        total_cnt++;
        if (lat != exp_lat)
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_bad != 0)
            $display("FAIL %s busy_in_ready: in_ready high %0d cycles required 0", name, busy_bad);
        else pass_cnt++;

        got = {bus.div_by_zero, bus.quotient, bus.remainder};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s result: dbz/q/r got %0b/%h/%h required %0b/%h/%h", name,
                     got[2*W], got[2*W-1:W], got[W-1:0], exp[2*W], exp[2*W-1:W], exp[W-1:0]);
        else pass_cnt++;

        first = got;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_valid !== 1'b1 ||
                {bus.div_by_zero, bus.quotient, bus.remainder} !== first) unstable++;
        end
        total_cnt++;
        if (unstable != 0)
            $display("FAIL %s hold_stable: %0d unstable cycles required 0", name, unstable);
        else pass_cnt++;

        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name,
                     bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        drive_idle();
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder} !== '0)
            $display("FAIL reset_outputs: ov/dbz/q/r %b/%b/%h/%h required all 0",
                     bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL reset_idle: in_ready=%b state=%0d required 1/0", bus.in_ready, dbg_state);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_basic;
        run_op(32'd100, 32'd7, 1'b0, 0, -1, 0, "div_100_7");
        run_op(32'd7, 32'd100, 1'b0, 0, -1, 0, "div_7_100");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, -1, 0, "div_max_1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, -1, 0, "div_max_max");
    endtask

    task automatic test_zero_div;
        run_op(32'd5, 32'd0, 1'b0, 0, -1, 0, "div_5_0");
        run_op(32'd0, 32'd0, 1'b0, 0, -1, 0, "div_0_0");
    endtask

    task automatic test_backpressure;
        run_op(32'd100, 32'd7, 1'b0, 10, -1, 0, "backpressure");
    endtask

    task automatic test_enable;
        run_op(32'd100, 32'd7, 1'b0, 0, 10, 5, "en_pause");
    endtask

    task automatic test_reset_mid;
        bus.in_valid = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (dbg_state !== 2'd1)
            $display("FAIL reset_mid_calc: state=%0d required 1", dbg_state);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder} !== '0)
            $display("FAIL reset_mid_outputs: ov/dbz/q/r %b/%b/%h/%h required all 0",
                     bus.out_valid, bus.div_by_zero, bus.quotient, bus.remainder);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_mid_ready: in_ready=%b required 1", bus.in_ready);
        else pass_cnt++;
        run_op(32'd9, 32'd3, 1'b0, 0, -1, 0, "after_reset_9_3");
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = W'($urandom_range(1, 15));
                1: b = $urandom;
                2: b = '0;
                default: b = a >> $urandom_range(0, 8);
            endcase
            run_op(a, b, 1'b0, $urandom_range(0, 3), -1, 0, "random_u");
        end
    endtask

`ifdef INT_DIV_SIGNED_EN
    task automatic test_signed;
        logic [W-1:0] a;
        logic [W-1:0] b;
        run_op(-32'sd7, 32'sd2, 1'b1, 0, -1, 0, "s_m7_2");
        run_op(32'sd7, -32'sd2, 1'b1, 0, -1, 0, "s_7_m2");
        run_op(-32'sd7, -32'sd2, 1'b1, 0, -1, 0, "s_m7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, -1, 0, "s_minneg_m1");
        run_op(-32'sd9, 32'sd0, 1'b1, 0, -1, 0, "s_zero_div");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? W'($signed(-$urandom_range(1, 20))) : $urandom;
            if (b == '0) b = 32'd3;
            run_op(a, b, 1'b1, $urandom_range(0, 2), -1, 0, "random_s");
        end
    endtask
`endif

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_basic();
        test_zero_div();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_back_to_back();
`ifdef INT_DIV_SIGNED_EN
        test_signed();
`endif
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
